// File: rtl/apb_dummy_arbiter.sv
// Round-robin arbiter that serialises simple req/gnt masters onto one APB slave port.
module apb_dummy_arbiter #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NB_MASTERS     = 2
) (
  input  logic                                      HCLK,
  input  logic                                      HRESETn,
  input  logic [NB_MASTERS-1:0]                     req_i,
  input  logic [NB_MASTERS-1:0][APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [NB_MASTERS-1:0]                     we_i,
  input  logic [NB_MASTERS-1:0][31:0]               wdata_i,
  output logic [NB_MASTERS-1:0]                     gnt_o,
  output logic [NB_MASTERS-1:0]                     rvalid_o,
  output logic [31:0]                               rdata_o,
  output logic                                      err_o,
  output logic [APB_ADDR_WIDTH-1:0]                 PADDR,
  output logic [31:0]                               PWDATA,
  output logic                                      PWRITE,
  output logic                                      PSEL,
  output logic                                      PENABLE,
  input  logic [31:0]                               PRDATA,
  input  logic                                      PREADY,
  input  logic                                      PSLVERR
);

  localparam int unsigned IDX_W = $clog2(NB_MASTERS);
  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   cand;
  logic [SUM_W-1:0]   cand_sum;
  logic               any_req;
  logic               grant;
  logic               complete;

  // Search requesters starting at rr_q, wrapping at NB_MASTERS; first hit wins.
  always_comb begin
    winner   = rr_q;
    any_req  = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      cand_sum = {1'b0, rr_q} + SUM_W'(i);
      if (cand_sum >= SUM_W'(NB_MASTERS)) begin
        cand_sum = cand_sum - SUM_W'(NB_MASTERS);
      end
      cand = IDX_W'(cand_sum);
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Pointer moves to the master just after the winner.
  always_comb begin
    if (winner == IDX_W'(NB_MASTERS - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = winner + IDX_W'(1);
    end
  end

  // Next-state logic: grant only from IDLE, fixed SETUP, ACCESS until PREADY.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant is combinational so the master sees it in the arbitration cycle; masked in reset.
  assign gnt_o = (grant && HRESETn) ? (NB_MASTERS'(1) << winner) : '0;

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning request fields and advance the round-robin pointer on grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
    end else if (grant) begin
      PADDR   <= addr_i[winner];
      PWDATA  <= wdata_i[winner];
      PWRITE  <= we_i[winner];
      owner_q <= winner;
      rr_q    <= rr_next;
    end
  end

  // APB phase strobes registered from the next state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      PSEL    <= (state_d != IDLE);
      PENABLE <= (state_d == ACCESS);
    end
  end

  // Response capture: one-cycle strobe to the owner, data/error held until the next response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= complete ? (NB_MASTERS'(1) << owner_q) : '0;
      if (complete) begin
        rdata_o <= PWRITE ? 32'h0 : PRDATA;
        err_o   <= PSLVERR;
      end
    end
  end

endmodule

// File: tb/tb_apb_dummy_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed and random traffic.
module tb_apb_dummy_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;

  logic                 HCLK;
  logic                 HRESETn;
  logic [N-1:0]         req_i;
  logic [N-1:0][AW-1:0] addr_i;
  logic [N-1:0]         we_i;
  logic [N-1:0][31:0]   wdata_i;
  logic [N-1:0]         gnt_o;
  logic [N-1:0]         rvalid_o;
  logic [31:0]          rdata_o;
  logic                 err_o;
  logic [AW-1:0]        PADDR;
  logic [31:0]          PWDATA;
  logic                 PWRITE;
  logic                 PSEL;
  logic                 PENABLE;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  apb_dummy_arbiter #(.APB_ADDR_WIDTH(AW), .NB_MASTERS(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: one transfer in flight, counted in cycles since grant
  bit            m_busy;
  int            m_cyc;
  int            m_rr;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [31:0]   m_wdata;
  logic [N-1:0]  m_rv;
  logic [31:0]   m_rdata;
  logic          m_err;

  // environment
  logic [31:0] mem [16];
  logic [N-1:0] gnt_seen;
  bit  rand_en;
  bit  rnd_slave;
  int  wait_left;
  bit  err_force;
  int  gq[$];
  int  gc[$];
  int  rc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_cyc = 0; m_rr = 0; m_owner = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0;
    m_rv = '0; m_rdata = '0; m_err = 1'b0;
  endtask

  // Compare DUT against the model, log events, then advance the model one cycle.
  task automatic monitor();
    logic [N-1:0] exp_gnt;
    logic [N-1:0] nrv;
    int w;
    w = -1;
    exp_gnt = '0;
    if (!HRESETn) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_i[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
    end
    if (w >= 0) exp_gnt = N'(1) << w;
    chk("gnt", 32'(gnt_o), 32'(exp_gnt));
    chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'(1));
    chk("psel", 32'(PSEL), 32'(m_busy));
    chk("penable", 32'(PENABLE), 32'(m_busy && m_cyc >= 2));
    chk("paddr", 32'(PADDR), 32'(m_addr));
    chk("pwrite", 32'(PWRITE), 32'(m_we));
    chk("pwdata", PWDATA, m_wdata);
    chk("rvalid", 32'(rvalid_o), 32'(m_rv));
    chk("rdata", rdata_o, m_rdata);
    chk("err", 32'(err_o), 32'(m_err));
    gnt_seen = gnt_o;
    for (int k = 0; k < N; k++) begin
      if (gnt_o[k]) begin gq.push_back(k); gc.push_back(cyc); end
    end
    if (rvalid_o != '0) rc.push_back(cyc);
    if (HRESETn) begin
      nrv = '0;
      if (m_busy) begin
        if (m_cyc >= 2 && PREADY) begin
          m_busy  = 1'b0;
          nrv     = N'(1) << m_owner;
          m_rdata = m_we ? 32'h0 : PRDATA;
          m_err   = PSLVERR;
        end else begin
          m_cyc++;
        end
      end else if (w >= 0) begin
        m_busy  = 1'b1;
        m_cyc   = 1;
        m_owner = w;
        m_addr  = addr_i[w];
        m_we    = we_i[w];
        m_wdata = wdata_i[w];
        m_rr    = (w + 1) % N;
      end
      m_rv = nrv;
    end
  endtask

  task automatic new_req(input int m);
    req_i[m]   = 1'b1;
    addr_i[m]  = AW'($urandom);
    we_i[m]    = 1'($urandom_range(0, 1));
    wdata_i[m] = $urandom;
  endtask

  // Slave memory and, when enabled, random masters; runs just after each rising edge.
  task automatic drive();
    if (rnd_slave) begin
      PREADY  = ($urandom_range(0, 2) != 0);
      PSLVERR = ($urandom_range(0, 7) == 0);
    end else begin
      if (PSEL && PENABLE && wait_left > 0) begin
        PREADY = 1'b0;
        wait_left--;
      end else begin
        PREADY = 1'b1;
      end
      PSLVERR = err_force;
    end
    PRDATA = (PSEL && !PWRITE) ? mem[PADDR[5:2]] : $urandom;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] = PWDATA;
    if (rand_en) begin
      for (int m = 0; m < N; m++) begin
        if (req_i[m] && gnt_seen[m]) begin
          if ($urandom_range(0, 1) == 1) new_req(m);
          else req_i[m] = 1'b0;
        end else if (!req_i[m] && $urandom_range(0, 3) == 0) begin
          new_req(m);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge HCLK);
    monitor();
    @(posedge HCLK);
    cyc++;
    #1;
    drive();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic we, input logic [31:0] d);
    req_i[m] = 1'b1; addr_i[m] = a; we_i[m] = we; wdata_i[m] = d;
  endtask

  initial begin
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    HRESETn = 1'b0;
    req_i = '0; addr_i = '0; we_i = '0; wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    rand_en = 1'b0; rnd_slave = 1'b0; wait_left = 0; err_force = 1'b0;
    gnt_seen = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    model_reset();
    idle(2);
    chk("rst_psel", 32'(PSEL), 32'(0));
    chk("rst_rvalid", 32'(rvalid_o), 32'(0));
    HRESETn = 1'b1;
    idle(2);

    // single read by master 0
    mem[0] = 32'h00DA41DE;
    set_req(0, 12'h000, 1'b0, 32'h0);
    #1 chk("t1_gnt", 32'(gnt_o), 32'h1);
    step(); req_i = '0;
    chk("t1_setup_psel", 32'(PSEL), 32'h1);
    chk("t1_setup_penable", 32'(PENABLE), 32'h0);
    step();
    chk("t1_access_penable", 32'(PENABLE), 32'h1);
    step();
    chk("t1_rvalid", 32'(rvalid_o), 32'h1);
    chk("t1_rdata", rdata_o, 32'h00DA41DE);
    chk("t1_err", 32'(err_o), 32'h0);
    chk("t1_model_rr", 32'(m_rr), 32'h1);
    idle(2);

    // master 1 write then readback
    set_req(1, 12'h004, 1'b1, 32'hCAFEF00D);
    #1 chk("t2_gnt_w", 32'(gnt_o), 32'h2);
    step(); req_i = '0;
    chk("t2_setup_pwrite", 32'(PWRITE), 32'h1);
    chk("t2_setup_pwdata", PWDATA, 32'hCAFEF00D);
    chk("t2_setup_paddr", 32'(PADDR), 32'h004);
    step();
    chk("t2_access_pwdata", PWDATA, 32'hCAFEF00D);
    chk("t2_access_penable", 32'(PENABLE), 32'h1);
    step();
    chk("t2_w_rvalid", 32'(rvalid_o), 32'h2);
    chk("t2_w_rdata", rdata_o, 32'h0);
    set_req(1, 12'h004, 1'b0, 32'h0);
    #1 chk("t2_gnt_r", 32'(gnt_o), 32'h2);
    step(); req_i = '0;
    idle(2);
    chk("t2_r_rvalid", 32'(rvalid_o), 32'h2);
    chk("t2_r_rdata", rdata_o, 32'hCAFEF00D);
    idle(2);

    // contention: both masters request continuously
    gq.delete(); gc.delete(); rc.delete();
    set_req(0, 12'h010, 1'b0, 32'h0);
    set_req(1, 12'h014, 1'b0, 32'h0);
    idle(18);
    req_i = '0;
    idle(2);
    chk("t3_ngrants", 32'(gq.size()), 32'd6);
    for (int k = 0; k < gq.size() && k < 6; k++) chk("t3_order", 32'(gq[k]), 32'(k % 2));
    for (int k = 1; k < gc.size() && k < 6; k++) chk("t3_gap", 32'(gc[k] - gc[k-1]), 32'd3);
    for (int k = 0; k + 1 < gc.size() && k < rc.size(); k++)
      chk("t3_b2b", 32'(rc[k]), 32'(gc[k+1]));
    chk("t3_model_rr", 32'(m_rr), 32'h0);

    // three wait states
    wait_left = 3;
    set_req(0, 12'h008, 1'b1, 32'h12345678);
    step(); req_i = '0;
    s_addr = PADDR; s_wdata = PWDATA;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_psel", 32'(PSEL), 32'h1);
      chk("t4_penable", 32'(PENABLE), 32'h1);
      chk("t4_paddr_stable", 32'(PADDR), 32'(s_addr));
      chk("t4_pwdata_stable", PWDATA, s_wdata);
      chk("t4_no_rvalid", 32'(rvalid_o), 32'h0);
    end
    step();
    chk("t4_rvalid_t6", 32'(rvalid_o), 32'h1);

    // slave error then clean transfer
    err_force = 1'b1;
    set_req(0, 12'h000, 1'b0, 32'h0);
    step(); req_i = '0;
    idle(2);
    chk("t5_rvalid", 32'(rvalid_o), 32'h1);
    chk("t5_err", 32'(err_o), 32'h1);
    err_force = 1'b0;
    set_req(1, 12'h004, 1'b0, 32'h0);
    step(); req_i = '0;
    idle(2);
    chk("t5_ok_rvalid", 32'(rvalid_o), 32'h2);
    chk("t5_ok_err", 32'(err_o), 32'h0);
    chk("t5_ok_rdata", rdata_o, 32'hCAFEF00D);
    idle(2);

    // reset during a stalled ACCESS phase
    wait_left = 1000;
    set_req(0, 12'h00C, 1'b0, 32'h0);
    step(); req_i = '0;
    idle(2);
    chk("t6_in_access", 32'(PENABLE), 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("t6_psel_drop", 32'(PSEL), 32'h0);
    chk("t6_penable_drop", 32'(PENABLE), 32'h0);
    wait_left = 0;
    set_req(0, 12'h000, 1'b0, 32'h0);
    set_req(1, 12'h004, 1'b0, 32'h0);
    #1 chk("t6_gnt_in_reset", 32'(gnt_o), 32'h0);
    idle(2);
    HRESETn = 1'b1;
    #1 chk("t6_gnt_after", 32'(gnt_o), 32'h1);
    step(); req_i[0] = 1'b0;
    chk("t6_no_rvalid", 32'(rvalid_o), 32'h0);
    idle(2);
    chk("t6_rvalid", 32'(rvalid_o), 32'h1);
    #1 chk("t6_gnt_m1", 32'(gnt_o), 32'h2);
    step(); req_i = '0;
    idle(4);

    // randomized traffic with occasional resets
    rand_en = 1'b1;
    rnd_slave = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        HRESETn = 1'b0;
        #1 chk("rand_rst_psel", 32'(PSEL), 32'h0);
        idle(2);
        HRESETn = 1'b1;
      end
    end
    rand_en = 1'b0;
    rnd_slave = 1'b0;
    req_i = '0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_dummy_arbiter.md
# apb_dummy_arbiter

Round-robin arbiter and APB master sequencer that lets several simple request/grant masters share one APB slave port, typically the dummy/scratch register peripheral in the APB domain. It accepts one transfer at a time, drives the APB SETUP/ACCESS phases, honours slave wait states and returns read data and error status to the winning requester.

## Interface

- APB_ADDR_WIDTH, 12, APB address width (4 KB slave window)
- NB_MASTERS, 2, number of requesters; legal range 2..8

Ports:

- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous, active-low; clock HCLK
- req_i  in  NB_MASTERS  per-master request, held until granted
- addr_i  in  NB_MASTERS x APB_ADDR_WIDTH  per-master address
- we_i  in  NB_MASTERS  per-master write enable (1 = write)
- wdata_i  in  NB_MASTERS x 32  per-master write data
- gnt_o  out  NB_MASTERS  one-hot grant, combinational, at most one bit high
- rvalid_o  out  NB_MASTERS  one-hot response strobe, registered, one cycle
- rdata_o  out  32  response read data (shared; valid with rvalid_o)
- err_o  out  1  response error (shared; valid with rvalid_o)
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation

- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- IDLE: if any req_i bit set, pick winner by searching from rr_q upward with wrap (rr_q first priority); assert gnt_o[winner] same cycle; latch addr/we/wdata of winner into PADDR/PWRITE/PWDATA registers and winner index into owner_q; rr_q <= (winner+1) mod NB_MASTERS; go SETUP. No request: stay IDLE, gnt_o = 0.
- SETUP: PSEL=1, PENABLE=0; unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=0: stay (wait state), PADDR/PWDATA/PWRITE stable. PREADY=1: capture PRDATA into rdata_o (writes capture 0) and PSLVERR into err_o, set rvalid_o[owner_q] next cycle, go IDLE.
- gnt_o only in IDLE; requests in other states wait. Requester may drop or change req_i after its grant cycle.
- Only one outstanding transfer; rdata_o/err_o hold last response until next response.
- Winner's request fields are sampled only in the grant cycle; later changes have no effect.

## Timing

- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rvalid_o=0, rdata_o=0, err_o=0, rr_q=0, owner_q=0; gnt_o=0 while reset asserted.
- Zero-wait-state transfer: grant cycle T (IDLE), SETUP T+1, ACCESS T+2 with PREADY=1, rvalid_o at T+3. Each PREADY=0 cycle in ACCESS adds one cycle.
- FSM is in IDLE at T+3, so a new grant can coincide with rvalid_o: peak throughput one transfer per 3 cycles.
- Simultaneous requests: exactly one grant; continuous requests from all masters are served strictly in rotation (0,1,...,N-1,0...).
- rr_q wraps from NB_MASTERS-1 to 0.
- Asynchronous reset mid-transfer (SETUP or ACCESS): PSEL/PENABLE drop immediately, FSM to IDLE, no rvalid_o issued for aborted transfer, rr_q=0.

## Test plan

- Single read: master 0 requests addr 0x000, slave returns PRDATA=0x00DA41DE, PREADY=1 -> gnt_o=01 at T, PSEL at T+1, PENABLE at T+2, rvalid_o=01, rdata_o=0x00DA41DE, err_o=0 at T+3.
- Write/readback: master 1 writes 0xCAFEF00D to 0x004, then reads 0x004 -> PWRITE=1, PWDATA=0xCAFEF00D in SETUP/ACCESS; read returns 0xCAFEF00D on rvalid_o=10.
- Contention: both masters hold req_i=11 for 6 transfers -> grants alternate 0,1,0,1,0,1; gnt_o never two bits high; back-to-back grant in same cycle as rvalid_o.
- Wait states: PREADY low 3 ACCESS cycles -> PADDR/PWDATA/PSEL/PENABLE stable, rvalid_o at T+6.
- Slave error: PSLVERR=1 with PREADY=1 -> err_o=1 with rvalid_o; next good transfer returns err_o=0.
- Reset in ACCESS with PREADY=0 -> PSEL=PENABLE=0 immediately, no rvalid_o, next request from master 1 with both requesting still gives master 0 first (rr_q=0).
